// File: rtl/ggt_pkg.sv
// ---------------------------------------------------------------------------
// ggt_pkg
//   Shared definitions for the GCD-core arbiter slice.
//   - GGT_WIDTH        : default operand/result width
//   - GGT_TIMEOUT_CYC  : default watchdog limit in BUSY cycles
//   - ggt_state_t      : arbiter FSM states
//   - wdog_width()     : watchdog counter width for a given timeout
// ---------------------------------------------------------------------------
package ggt_pkg;

  localparam int GGT_WIDTH       = 16;
  localparam int GGT_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } ggt_state_t;

  // The watchdog counts 0 .. timeout-1, so $clog2(timeout) bits suffice.
  // A degenerate timeout of 1 still needs a 1-bit counter.
  function automatic int wdog_width(input int timeout_cyc);
    return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
  endfunction

  localparam int GGT_WDOG_W = wdog_width(GGT_TIMEOUT_CYC);

endpackage

// File: rtl/rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
//   Combinational round-robin picker. Starting at slot ptr and wrapping
//   modulo N_REQ, returns the first requester whose req bit is set.
//
//   Ports:
//     req  in  N_REQ  : pending request vector
//     ptr  in  IDX_W  : slot with highest priority this round (< N_REQ)
//     gnt  out N_REQ  : one-hot pick (all zero when nothing pending)
//     idx  out IDX_W  : index of the picked slot
//     any  out 1      : at least one request pending
// ---------------------------------------------------------------------------
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One extra bit so ptr + i (at most 2*N_REQ-2) never overflows before
  // the modulo wrap.
  logic [IDX_W:0] slot;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    slot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      slot = {1'b0, ptr} + (IDX_W+1)'(i);
      if (slot >= (IDX_W+1)'(N_REQ)) begin
        slot = slot - (IDX_W+1)'(N_REQ);
      end
      if (!any && req[slot[IDX_W-1:0]]) begin
        any                   = 1'b1;
        gnt[slot[IDX_W-1:0]]  = 1'b1;
        idx                   = slot[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ggt_arbiter.sv
// ---------------------------------------------------------------------------
// ggt_arbiter
//   Shares one ggt_top GCD core between N_REQ requesters. A pending request
//   is picked round-robin in IDLE, its operands are latched, and the job is
//   either answered directly (an operand is zero) or handed to the core.
//   The result is returned to the granted requester with a one-cycle
//   done pulse. A watchdog aborts a job whose core never answers.
//
//   Ports:
//     clk             in  1           : clock, rising edge
//     rst_i           in  1           : synchronous reset, active low
//     req_i           in  N_REQ       : request per requester
//     zahl1_i         in  N_REQ*WIDTH : operand A, requester k at [k*WIDTH +: WIDTH]
//     zahl2_i         in  N_REQ*WIDTH : operand B, same packing
//     gnt_o           out N_REQ       : one-hot pulse, operands captured
//     done_o          out N_REQ       : one-hot pulse, result valid
//     ergebnis_o      out WIDTH       : result, valid with done_o
//     err_o           out 1           : watchdog abort flag, valid with done_o
//     ggt_start_o     out 1           : start pulse to the core
//     ggt_zahl1_o     out WIDTH       : operand A to the core
//     ggt_zahl2_o     out WIDTH       : operand B to the core
//     ggt_valid_i     in  1           : core result valid (level)
//     ggt_ergebnis_i  in  WIDTH       : core result
// ---------------------------------------------------------------------------
module ggt_arbiter
  import ggt_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = GGT_WIDTH,
  parameter int TIMEOUT_CYC = GGT_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] zahl1_i,
  input  logic [N_REQ*WIDTH-1:0] zahl2_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [WIDTH-1:0]       ergebnis_o,
  output logic                   err_o,
  output logic                   ggt_start_o,
  output logic [WIDTH-1:0]       ggt_zahl1_o,
  output logic [WIDTH-1:0]       ggt_zahl2_o,
  input  logic                   ggt_valid_i,
  input  logic [WIDTH-1:0]       ggt_ergebnis_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = wdog_width(TIMEOUT_CYC);

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  ggt_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  sel_idx;
  logic [N_REQ-1:0]  sel_oh;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic              zero_f;
  logic              vld_p1;
  logic [WD_W-1:0]   wdog;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [WIDTH-1:0]  pick_a;
  logic [WIDTH-1:0]  pick_b;
  logic              vld_rise;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Operand mux driven by the one-hot pick, so no index arithmetic on
  // the wide packed buses.
  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_a = zahl1_i[i*WIDTH +: WIDTH];
        pick_b = zahl2_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only a fresh rising edge counts: a valid level still high from the
  // previous job must not complete the current one.
  assign vld_rise = ggt_valid_i & ~vld_p1;

  assign ggt_zahl1_o = opa;
  assign ggt_zahl2_o = opb;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      sel_idx     <= '0;
      sel_oh      <= '0;
      opa         <= '0;
      opb         <= '0;
      zero_f      <= 1'b0;
      vld_p1      <= 1'b0;
      wdog        <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      ergebnis_o  <= '0;
      err_o       <= 1'b0;
      ggt_start_o <= 1'b0;
    end else begin
      vld_p1      <= ggt_valid_i;

      // All handshake outputs are single-cycle pulses.
      gnt_o       <= '0;
      done_o      <= '0;
      ergebnis_o  <= '0;
      err_o       <= 1'b0;
      ggt_start_o <= 1'b0;

      unique case (state)
        // ---- IDLE -> START: pick, capture operands, raise gnt/start ----
        IDLE: begin
          if (pick_any) begin
            sel_oh      <= pick_oh;
            sel_idx     <= pick_idx;
            opa         <= pick_a;
            opb         <= pick_b;
            zero_f      <= (pick_a == '0) || (pick_b == '0);
            gnt_o       <= pick_oh;
            // Start is decided here so it appears in the START cycle
            // together with gnt_o; zero jobs never touch the core.
            ggt_start_o <= (pick_a != '0) && (pick_b != '0);
            state       <= START;
          end
        end

        // ---- START -> DONE (zero bypass) or BUSY (core running) ----
        START: begin
          wdog <= '0;
          if (zero_f) begin
            // gcd(a,0) = a and gcd(0,0) = 0, i.e. simply a | b.
            done_o     <= sel_oh;
            ergebnis_o <= opa | opb;
            state      <= DONE;
          end else begin
            state      <= BUSY;
          end
        end

        // ---- BUSY -> DONE on core edge or watchdog expiry ----
        BUSY: begin
          if (vld_rise) begin
            done_o     <= sel_oh;
            ergebnis_o <= ggt_ergebnis_i;
            state      <= DONE;
          end else if (wdog == WD_LAST) begin
            done_o     <= sel_oh;
            err_o      <= 1'b1;
            state      <= DONE;
          end else begin
            wdog       <= wdog + WD_W'(1);
          end
        end

        // ---- DONE -> IDLE: served slot drops to lowest priority ----
        DONE: begin
          ptr   <= next_ptr(sel_idx);
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ggt_arbiter.sv
module tb_ggt_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic [N-1:0]     req_i = '0;
  logic [N*W-1:0]   zahl1_i = '0;
  logic [N*W-1:0]   zahl2_i = '0;
  logic [N-1:0]     gnt_o;
  logic [N-1:0]     done_o;
  logic [W-1:0]     ergebnis_o;
  logic             err_o;
  logic             ggt_start_o;
  logic [W-1:0]     ggt_zahl1_o;
  logic [W-1:0]     ggt_zahl2_o;
  logic             ggt_valid_i = 1'b0;
  logic [W-1:0]     ggt_ergebnis_i = '0;

  always #5 clk = ~clk;

  ggt_arbiter #(
    .N_REQ       (N),
    .WIDTH       (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .zahl1_i        (zahl1_i),
    .zahl2_i        (zahl2_i),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .ergebnis_o     (ergebnis_o),
    .err_o          (err_o),
    .ggt_start_o    (ggt_start_o),
    .ggt_zahl1_o    (ggt_zahl1_o),
    .ggt_zahl2_o    (ggt_zahl2_o),
    .ggt_valid_i    (ggt_valid_i),
    .ggt_ergebnis_i (ggt_ergebnis_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference gcd from the plain rules: zero operand -> a|b, else Euclid.
  function automatic int gcd_ref(input int a, input int b);
    int x, y, t;
    if (a == 0 || b == 0) return a | b;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // ---------------- core stub (subtractive gcd, random latency) ----------
  bit  st_hang = 0;
  bit  st_run  = 0;
  int  st_cnt  = 0;
  int  lat_min = 1;
  int  lat_max = 6;

  function automatic logic [W-1:0] gcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    if (a == '0 || b == '0) return a | b;
    x = a; y = b;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
    end
    return x;
  endfunction

  // Valid stays high after a result until the next job is running, so a
  // stale level overlaps the first BUSY cycle of the following job.
  always @(posedge clk) begin
    if (!rst_i) begin
      ggt_valid_i    <= 1'b0;
      ggt_ergebnis_i <= '0;
      st_run         <= 1'b0;
      st_cnt         <= 0;
    end else if (ggt_start_o) begin
      st_run         <= !st_hang;
      st_cnt         <= int'($urandom_range(lat_max, lat_min));
      ggt_ergebnis_i <= gcd_sub(ggt_zahl1_o, ggt_zahl2_o);
    end else if (st_run) begin
      if (st_cnt == 0) begin
        ggt_valid_i <= 1'b1;
        st_run      <= 1'b0;
      end else begin
        ggt_valid_i <= 1'b0;
        st_cnt      <= st_cnt - 1;
      end
    end
  end

  // ---------------- requesters ------------------------------------------
  int q_a[N][$];
  int q_b[N][$];
  int cur_a[N];
  int cur_b[N];
  bit gnt_seen[N];

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (gnt_seen[k]) begin
        gnt_seen[k] = 1'b0;
        if (q_a[k].size() > 0) begin
          void'(q_a[k].pop_front());
          void'(q_b[k].pop_front());
        end
      end
      if (q_a[k].size() > 0) begin
        req_i[k] = 1'b1; cur_a[k] = q_a[k][0]; cur_b[k] = q_b[k][0];
      end else begin
        req_i[k] = 1'b0; cur_a[k] = 0; cur_b[k] = 0;
      end
      zahl1_i[k*W +: W] = W'(cur_a[k]);
      zahl2_i[k*W +: W] = W'(cur_b[k]);
    end
  end

  task automatic push(input int k, input int a, input int b);
    q_a[k].push_back(a);
    q_b[k].push_back(b);
  endtask

  // ---------------- monitor + reference model ---------------------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit           m_active = 0;
  bit           m_zero, m_hang, m_err;
  int           m_ptr = 0, m_idle = 0, m_k = 0, m_done = -1, m_res = 0;
  logic [N-1:0] req_prev = '0;
  logic         valid_prev = 1'b0;
  logic         rst_prev = 1'b0;

  int gnt_log[$];
  int res_log[$];
  int last_res = -1, last_err = -1, last_idx = -1;
  int last_gnt_c = 0, last_done_c = 0;
  int start_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    int c, k;
    logic [N-1:0] exp_gnt, exp_done;
    logic exp_start;
    c = cyc; exp_gnt = '0; exp_done = '0; exp_start = 1'b0;

    if (ggt_start_o) start_cnt++;
    for (int i = 0; i < N; i++) begin
      if (gnt_o[i]) begin gnt_log.push_back(i); gnt_seen[i] = 1'b1; last_gnt_c = c; end
      if (done_o[i]) begin
        last_idx = i; last_res = int'(ergebnis_o); last_err = int'(err_o);
        res_log.push_back(int'(ergebnis_o)); last_done_c = c; done_cnt++;
      end
    end

    if (!rst_prev) begin
      chk("rst_gnt",   32'(gnt_o), 0);
      chk("rst_done",  32'(done_o), 0);
      chk("rst_start", 32'(ggt_start_o), 0);
      chk("rst_err",   32'(err_o), 0);
      chk("rst_res",   32'(ergebnis_o), 0);
      chk("rst_z1",    32'(ggt_zahl1_o), 0);
      chk("rst_z2",    32'(ggt_zahl2_o), 0);
      m_active = 0; m_ptr = 0; m_idle = c;
    end else begin
      if (!m_active && (c - 1) >= m_idle && req_prev != '0) begin
        k = -1;
        for (int i = 0; i < N; i++)
          if (k < 0 && req_prev[(m_ptr + i) % N]) k = (m_ptr + i) % N;
        exp_gnt[k] = 1'b1;
        m_active = 1; m_k = k;
        m_zero = (cur_a[k] == 0) || (cur_b[k] == 0);
        m_hang = st_hang;
        exp_start = !m_zero;
        if (m_zero) begin
          m_done = c + 1; m_res = cur_a[k] | cur_b[k]; m_err = 0;
        end else if (m_hang) begin
          m_done = c + 1 + TO; m_res = 0; m_err = 1;
        end else begin
          m_done = -1; m_res = gcd_ref(cur_a[k], cur_b[k]); m_err = 0;
          chk("core_z1", 32'(ggt_zahl1_o), cur_a[k]);
          chk("core_z2", 32'(ggt_zahl2_o), cur_b[k]);
        end
      end else if (m_active && !m_zero && !m_hang && m_done < 0 &&
                   ggt_valid_i && !valid_prev) begin
        m_done = c + 1;
      end

      if (m_active && c == m_done) exp_done[m_k] = 1'b1;
      chk("gnt",   32'(gnt_o), 32'(exp_gnt));
      chk("start", 32'(ggt_start_o), 32'(exp_start));
      chk("done",  32'(done_o), 32'(exp_done));
      if (exp_done != '0) begin
        chk("result", 32'(ergebnis_o), m_res);
        chk("err",    32'(err_o), 32'(m_err));
        m_active = 0; m_ptr = (m_k + 1) % N; m_idle = c + 1;
      end
    end

    valid_prev = ggt_valid_i;
    req_prev   = req_i;
    rst_prev   = rst_i;
  end

  // ---------------- sequencing helpers ----------------------------------
  function automatic bit queues_empty();
    for (int k = 0; k < N; k++) if (q_a[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int gnt_at(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : -1;
  endfunction

  function automatic int res_at(input int i);
    return (i < res_log.size()) ? res_log[i] : -1;
  endfunction

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if (queues_empty() && !m_active && req_i == '0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    chk({"idle_", tag}, 32'(ok), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- stimulus --------------------------------------------
  initial begin
    int sc, dc, a, b, k;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single request
    sc = start_cnt;
    push(0, 48, 18);
    wait_idle("single");
    chk("single_res",    32'(last_res), 6);
    chk("single_idx",    32'(last_idx), 0);
    chk("single_err",    32'(last_err), 0);
    chk("single_starts", 32'(start_cnt - sc), 1);

    // contention from pointer 0
    pulse_reset();
    repeat (2) @(posedge clk); #1;
    gnt_log.delete(); res_log.delete();
    push(1, 35, 14);
    push(3, 81, 27);
    wait_idle("cont");
    chk("cont_g0", 32'(gnt_at(0)), 1);
    chk("cont_g1", 32'(gnt_at(1)), 3);
    chk("cont_r0", 32'(res_at(0)), 7);
    chk("cont_r1", 32'(res_at(1)), 27);

    // fairness: every requester holds two jobs; pointer is back at 0
    gnt_log.delete();
    for (int j = 0; j < 2; j++)
      for (int r = 0; r < N; r++)
        push(r, int'($urandom_range(3000, 1)), int'($urandom_range(3000, 1)));
    wait_idle("fair");
    for (int i = 0; i < 8; i++) chk($sformatf("fair_g%0d", i), 32'(gnt_at(i)), i % N);

    // zero bypass
    sc = start_cnt; res_log.delete();
    push(2, 0, 7); push(2, 12, 0); push(2, 0, 0);
    wait_idle("zero");
    chk("zero_r0", 32'(res_at(0)), 7);
    chk("zero_r1", 32'(res_at(1)), 12);
    chk("zero_r2", 32'(res_at(2)), 0);
    chk("zero_starts", 32'(start_cnt - sc), 0);
    chk("zero_lat", 32'(last_done_c - last_gnt_c), 1);

    // watchdog
    st_hang = 1;
    push(0, 48, 18);
    wait_idle("wd");
    chk("wd_err", 32'(last_err), 1);
    chk("wd_res", 32'(last_res), 0);
    chk("wd_lat", 32'(last_done_c - last_gnt_c), TO + 1);
    st_hang = 0;
    push(0, 48, 18);
    wait_idle("wd_next");
    chk("wd_next_res", 32'(last_res), 6);
    chk("wd_next_err", 32'(last_err), 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(N - 1, 0));
      a = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(5000, 1));
      b = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(5000, 1));
      push(k, a, b);
      repeat (int'($urandom_range(4, 0))) @(posedge clk);
      #1;
    end
    wait_idle("rand");

    // reset in the middle of a core job
    lat_min = 12; lat_max = 12;
    gnt_log.delete();
    push(1, 48, 18);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (gnt_log.size() > 0) begin seen = 1'b1; break; end
    end
    chk("rst_job_granted", 32'(seen), 1);
    repeat (3) @(posedge clk);
    dc = done_cnt;
    #1 rst_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b1;
    repeat (25) @(posedge clk);
    chk("rst_no_done", 32'(done_cnt - dc), 0);
    #1;
    lat_min = 1; lat_max = 6;
    push(1, 48, 18);
    wait_idle("rst_rejob");
    chk("rst_rejob_res", 32'(last_res), 6);
    chk("rst_rejob_err", 32'(last_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
